// File: rtl/alu_seq_ctrl.sv
// Sequencing controller that chains one ALU opcode across a run-time number of operands.
// Moore FSM: all datapath controls are decoded from the registered state.
module alu_seq_ctrl #(
   parameter int OP_W    = 3,
   parameter int NUM_OPS = 4,
   parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [OP_W-1:0]  opcode,
   input  logic [CNT_W-1:0] num_operands,
   output logic             ld_a,
   output logic             ld_b,
   output logic             sel_a,
   output logic [OP_W-1:0]  op_sel,
   output logic             alu_en,
   output logic [CNT_W-1:0] opnd_idx,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(2);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_OPS);

   state_t           state_q, state_d;
   logic [OP_W-1:0]  op_q;
   logic [CNT_W-1:0] cnt_q, idx_q;
   logic             err_q;
   logic             req, cnt_legal, start_ok, start_bad, last_opnd;

   assign req       = (state_q == S_IDLE) && start && !abort;
   assign cnt_legal = (num_operands >= MIN_CNT) && (num_operands <= MAX_CNT);
   assign start_ok  = req && cnt_legal;
   assign start_bad = req && !cnt_legal;
   assign last_opnd = (idx_q == cnt_q - CNT_W'(1));

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= start_bad;
         if (start_ok) begin
            op_q  <= opcode;
            cnt_q <= num_operands;
            idx_q <= '0;
         end else if (state_q == S_LOAD_A) begin
            idx_q <= CNT_W'(1);
         end else if (state_q == S_WB && !abort && !last_opnd) begin
            idx_q <= idx_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:   state_d = start_ok ? S_LOAD_A : S_IDLE;
         S_LOAD_A: state_d = abort ? S_IDLE : S_LOAD_B;
         S_LOAD_B: state_d = abort ? S_IDLE : S_EXEC;
         S_EXEC:   state_d = abort ? S_IDLE : S_WB;
         S_WB:     state_d = abort ? S_IDLE : (last_opnd ? S_DONE : S_LOAD_B);
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      sel_a    = 1'b0;
      op_sel   = '0;
      alu_en   = 1'b0;
      opnd_idx = '0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_LOAD_A: begin
            busy = 1'b1;
            ld_a = 1'b1;
         end
         S_LOAD_B: begin
            busy     = 1'b1;
            ld_b     = 1'b1;
            opnd_idx = idx_q;
         end
         S_EXEC: begin
            busy   = 1'b1;
            alu_en = 1'b1;
            op_sel = op_q;
         end
         S_WB: begin
            busy   = 1'b1;
            ld_a   = 1'b1;
            sel_a  = 1'b1;
            op_sel = op_q;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign err   = err_q;
   assign state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_alu_seq_ctrl;

   localparam int OP_W  = 3;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n, start, abort;
   logic [OP_W-1:0]  opcode;
   logic [CNT_W-1:0] num_operands;
   logic             ld_a, ld_b, sel_a, alu_en, busy, done, err;
   logic [OP_W-1:0]  op_sel;
   logic [CNT_W-1:0] opnd_idx;
   logic [2:0]       state;

   alu_seq_ctrl #(.OP_W(OP_W), .NUM_OPS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .opcode(opcode), .num_operands(num_operands),
      .ld_a(ld_a), .ld_b(ld_b), .sel_a(sel_a), .op_sel(op_sel),
      .alu_en(alu_en), .opnd_idx(opnd_idx), .busy(busy), .done(done),
      .err(err), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] v;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic end_req = 1'b0;
   logic end_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Packed view: {state, busy, done, err, ld_a, ld_b, sel_a, alu_en, op_sel, opnd_idx}
   function automatic logic [15:0] pk(int st, int bz, int dn, int er, int la, int lb,
                                      int sa, int ae, int os, int ix);
      return {3'(st), 1'(bz), 1'(dn), 1'(er), 1'(la), 1'(lb), 1'(sa), 1'(ae), 3'(os), 3'(ix)};
   endfunction

   task automatic push(int c, logic [15:0] v, string tag, int last);
      if (c <= last) sb_q.push_back('{cyc: c, v: v, tag: tag});
   endtask

   task automatic push_idle(int from, int to);
      for (int c = from; c <= to; c++) push(c, '0, "idle", to);
   endtask

   // Expected trace of a sequence started in cycle c0, truncated after cycle last.
   task automatic push_run(int c0, int n, int op, int last);
      push(c0 + 1, pk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0), "load_a", last);
      for (int k = 1; k < n; k++) begin
         push(c0 + 3*k - 1, pk(2, 1, 0, 0, 0, 1, 0, 0, 0, k),  "load_b", last);
         push(c0 + 3*k,     pk(3, 1, 0, 0, 0, 0, 0, 1, op, 0), "exec",   last);
         push(c0 + 3*k + 1, pk(4, 1, 0, 0, 1, 0, 1, 0, op, 0), "wb",     last);
      end
      push(c0 + 3*n - 1, pk(5, 1, 1, 0, 0, 0, 0, 0, 0, 0), "done", last);
      push(c0 + 3*n, '0, "idle", last);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [15:0] obs;
      exp_t        e;
      obs = {state, busy, done, err, ld_a, ld_b, sel_a, alu_en, op_sel, opnd_idx};
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s stale expectation: due cyc=%0d, now cyc=%0d", e.tag, e.cyc, cyc);
         end else if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b required=%b", e.tag, cyc, obs, e.v);
         end
      end
      if (end_req && !end_done) begin
         end_done = 1'b1;
         n_checks++;
         if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never reached", sb_q.size());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int bad_cnt[3] = '{1, 5, 0};
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      opcode = '0; num_operands = '0;

      // Reset held for two edges; outputs must be clean zeros (no X).
      tick();
      push_idle(cyc, cyc + 2);
      tick();
      rst_n = 1'b1;
      tick();

      // N=2, opcode 2.
      tick(); c0 = cyc;
      start = 1'b1; opcode = 3'b010; num_operands = 3'd2;
      push_run(c0, 2, 2, c0 + 6);
      tick(); start = 1'b0;
      repeat (5) tick();

      // N=4 with an ignored start while busy, back-to-back restart, abort in DONE.
      tick(); c0 = cyc;
      start = 1'b1; opcode = 3'd5; num_operands = 3'd4;
      push_run(c0, 4, 5, c0 + 12);
      tick(); start = 1'b0;
      repeat (4) tick();
      start = 1'b1; opcode = 3'd7; num_operands = 3'd3;
      tick(); start = 1'b0;
      repeat (6) tick();
      start = 1'b1; opcode = 3'd1; num_operands = 3'd2;
      push_run(c0 + 12, 2, 1, c0 + 18);
      tick(); start = 1'b0;
      repeat (4) tick();
      abort = 1'b1;
      tick(); abort = 1'b0;

      // Rejected counts pulse err one cycle later and never leave IDLE.
      foreach (bad_cnt[i]) begin
         tick(); c0 = cyc;
         start = 1'b1; num_operands = 3'(bad_cnt[i]);
         push(c0 + 1, pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "err_pulse", c0 + 1);
         push(c0 + 2, '0, "err_clear", c0 + 2);
         tick(); start = 1'b0;
         tick();
      end

      // abort blocks a legal start in IDLE, with no err.
      tick(); c0 = cyc;
      start = 1'b1; abort = 1'b1; num_operands = 3'd3;
      push_idle(c0 + 1, c0 + 2);
      tick(); start = 1'b0; abort = 1'b0;
      tick();

      // Abort in EXEC of an N=3 run, then a fresh N=2 sequence.
      tick(); c0 = cyc;
      start = 1'b1; opcode = 3'd6; num_operands = 3'd3;
      push_run(c0, 3, 6, c0 + 3);
      tick(); start = 1'b0;
      tick();
      tick();
      abort = 1'b1; start = 1'b1; num_operands = 3'd2;
      push_idle(c0 + 4, c0 + 5);
      tick(); abort = 1'b0; start = 1'b0;
      tick();
      start = 1'b1; opcode = 3'd3; num_operands = 3'd2;
      push_run(c0 + 5, 2, 3, c0 + 11);
      tick(); start = 1'b0;
      repeat (5) tick();

      // Reset in cycle 4 of an N=4 run; opcode toggled while busy.
      tick(); c0 = cyc;
      start = 1'b1; opcode = 3'd4; num_operands = 3'd4;
      push_run(c0, 4, 4, c0 + 4);
      tick(); start = 1'b0;
      tick(); opcode = 3'd7;
      tick();
      tick(); rst_n = 1'b0;
      push_idle(c0 + 5, c0 + 14);
      tick(); rst_n = 1'b1;
      repeat (9) tick();

      end_req = 1'b1;
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
